logo_rom_arbiter: RTL and testbench

- Shares the single-port logo ROM between two requesters.
- The VGA pixel fetch path has absolute priority.
- A background burst reader uses the remaining cycles, for example for sprite-collision probing or a checksum of the logo.
- Sits between the pixel-address generator/demo logic and the ROM instance, in the vga_clk domain.

---
 rtl/logo_rom_arb_pkg.sv | 18 +
 rtl/logo_rom_arbiter_if.sv | 51 +++++
 rtl/rom_tag_pipe.sv | 32 +++
 rtl/logo_rom_arbiter.sv | 119 +++++++++++
 tb/tb_logo_rom_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/logo_rom_arb_pkg.sv
// Shared types and constants for the logo ROM arbiter.
package logo_rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic [1:0] tag_t;

    localparam tag_t TAG_NONE = 2'd0;
    localparam tag_t TAG_PIX  = 2'd1;
    localparam tag_t TAG_BG   = 2'd2;

    localparam int ROM_LAT_DEF = 2;

endpackage

// File: rtl/logo_rom_arbiter_if.sv
// Request/response bundle of logo_rom_arbiter.
// Stats outputs exist only with LOGO_ROM_ARB_STATS_EN defined.
interface logo_rom_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
);
    logic              pix_req_i;
    logic [ADDR_W-1:0] pix_addr_i;
    logic [DATA_W-1:0] pix_data_o;
    logic              pix_valid_o;
    logic              bg_start_i;
    logic [ADDR_W-1:0] bg_base_i;
    logic [LEN_W-1:0]  bg_len_i;
    logic              bg_abort_i;
    logic              bg_busy_o;
    logic [DATA_W-1:0] bg_data_o;
    logic              bg_valid_o;
    logic              bg_done_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_q_i;
`ifdef LOGO_ROM_ARB_STATS_EN
    logic [15:0]       stall_cnt_o;
    logic [7:0]        burst_cnt_o;
`endif

    modport slave (
        input  pix_req_i, pix_addr_i,
        input  bg_start_i, bg_base_i, bg_len_i, bg_abort_i,
        input  rom_q_i,
        output pix_data_o, pix_valid_o,
        output bg_busy_o, bg_data_o, bg_valid_o, bg_done_o,
        output rom_addr_o
`ifdef LOGO_ROM_ARB_STATS_EN
        , output stall_cnt_o, burst_cnt_o
`endif
    );

    modport master (
        output pix_req_i, pix_addr_i,
        output bg_start_i, bg_base_i, bg_len_i, bg_abort_i,
        output rom_q_i,
        input  pix_data_o, pix_valid_o,
        input  bg_busy_o, bg_data_o, bg_valid_o, bg_done_o,
        input  rom_addr_o
`ifdef LOGO_ROM_ARB_STATS_EN
        , input stall_cnt_o, burst_cnt_o
`endif
    );

endinterface

// File: rtl/rom_tag_pipe.sv
// Owner-tag shift register that tracks each ROM read until its data returns.
module rom_tag_pipe
    import logo_rom_arb_pkg::*;
#(
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic clk,
    input  logic arst_n,
    input  tag_t tag_i,
    output tag_t tag_o,
    output logic bg_any_o
);
    tag_t tags_q [ROM_LAT];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < ROM_LAT; i++) tags_q[i] <= TAG_NONE;
        end else begin
            tags_q[0] <= tag_i;
            for (int i = 1; i < ROM_LAT; i++) tags_q[i] <= tags_q[i-1];
        end
    end

    assign tag_o = tags_q[ROM_LAT-1];

    always_comb begin
        bg_any_o = 1'b0;
        for (int i = 0; i < ROM_LAT; i++)
            if (tags_q[i] == TAG_BG) bg_any_o = 1'b1;
    end

endmodule

// File: rtl/logo_rom_arbiter.sv
// Logo ROM arbiter: pixel fetch has absolute priority, bursts fill idle slots.
// Optional stall/burst counters with LOGO_ROM_ARB_STATS_EN.
module logo_rom_arbiter
    import logo_rom_arb_pkg::*;
#(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = ROM_LAT_DEF,
    parameter int LEN_W   = 8
) (
    input  logic              clk,
    input  logic              arst_n,
    logo_rom_arbiter_if.slave bus
);
    state_t            state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic              done_q;
    logic              pix_valid_q;
    logic              bg_valid_q;
    logic [DATA_W-1:0] pix_data_q;
    logic [DATA_W-1:0] bg_data_q;
    logic              issue;
    logic              bg_inflight;
    tag_t              tag_in;
    tag_t              tag_out;

    always_comb begin
        issue  = (state_q == RUN) && !bus.pix_req_i;
        tag_in = TAG_NONE;
        if (bus.pix_req_i) tag_in = TAG_PIX;
        else if (issue)    tag_in = TAG_BG;
    end

    assign bus.rom_addr_o = issue ? cur_addr_q : bus.pix_addr_i;

    rom_tag_pipe #(.ROM_LAT(ROM_LAT)) u_tags (
        .clk      (clk),
        .arst_n   (arst_n),
        .tag_i    (tag_in),
        .tag_o    (tag_out),
        .bg_any_o (bg_inflight)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (bus.bg_start_i) begin
                    cur_addr_q <= bus.bg_base_i;
                    remain_q   <= bus.bg_len_i;
                    state_q    <= RUN;
                end
                RUN: if (issue) begin
                    cur_addr_q <= cur_addr_q + ADDR_W'(1);
                    remain_q   <= remain_q - LEN_W'(1);
                    if (remain_q == '0 || bus.bg_abort_i) state_q <= DRAIN;
                end else if (bus.bg_abort_i) begin
                    state_q <= DRAIN;
                end
                DRAIN: if (!bg_inflight) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data is captured off rom_q_i, so valid lands ROM_LAT+1 after issue.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            bg_valid_q  <= 1'b0;
            bg_data_q   <= '0;
        end else begin
            pix_valid_q <= (tag_out == TAG_PIX);
            pix_data_q  <= (tag_out == TAG_PIX) ? bus.rom_q_i : '0;
            bg_valid_q  <= (tag_out == TAG_BG);
            bg_data_q   <= (tag_out == TAG_BG) ? bus.rom_q_i : '0;
        end
    end

    assign bus.pix_valid_o = pix_valid_q;
    assign bus.pix_data_o  = pix_data_q;
    assign bus.bg_valid_o  = bg_valid_q;
    assign bus.bg_data_o   = bg_data_q;
    assign bus.bg_done_o   = done_q;
    assign bus.bg_busy_o   = (state_q != IDLE);

`ifdef LOGO_ROM_ARB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [7:0]  burst_cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
            burst_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && bus.bg_start_i)
                stall_cnt_q <= '0;
            else if (state_q == RUN && bus.pix_req_i && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (state_q == DRAIN && !bg_inflight)
                burst_cnt_q <= burst_cnt_q + 8'd1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.burst_cnt_o = burst_cnt_q;
`endif

endmodule

// File: tb/tb_logo_rom_arbiter.sv
// Self-checking bench for logo_rom_arbiter: directed burst table,
// pixel sweep, reset mid-burst and random traffic against a latency model.
module tb_logo_rom_arbiter;
    import logo_rom_arb_pkg::*;

    localparam int AW   = 15;
    localparam int DW   = 16;
    localparam int LW   = 8;
    localparam int LAT  = ROM_LAT_DEF;
    localparam int NCYC = 4096;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #20 clk = ~clk;

    logo_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    logo_rom_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .LEN_W(LW)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    // Model ROM: word at address a reads back as a, LAT cycles later.
    logic [AW-1:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= bus.rom_addr_o;
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_q_i = DW'(rom_pipe[LAT-1]);

    // Expected outputs scheduled by absolute cycle number.
    bit          exp_pv [NCYC];
    bit [DW-1:0] exp_pd [NCYC];
    bit          exp_bv [NCYC];
    bit [DW-1:0] exp_bd [NCYC];
    bit          exp_dn [NCYC];

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    // Burst model: words left to issue, next address, drain deadline.
    bit            m_burst = 0;
    bit            m_drain = 0;
    logic [AW-1:0] m_next = '0;
    int            m_left = 0;
    int            m_last_issue = -100;
    int            m_done_cyc = 0;
    int            m_issues = 0;

    int beats, dones, first_d, last_d, last_beat_cyc, done_gap;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_idle();
        return !m_burst || (m_drain && cyc >= m_done_cyc);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic step(input bit preq, input logic [AW-1:0] paddr,
                        input bit start, input logic [AW-1:0] base,
                        input logic [LW-1:0] len, input bit abort);
        bit running;
        @(negedge clk);
        chk("pix_valid", 32'(bus.pix_valid_o), 32'(exp_pv[cyc]));
        chk("pix_data",  32'(bus.pix_data_o),  32'(exp_pd[cyc]));
        chk("bg_valid",  32'(bus.bg_valid_o),  32'(exp_bv[cyc]));
        chk("bg_data",   32'(bus.bg_data_o),   32'(exp_bd[cyc]));
        chk("bg_done",   32'(bus.bg_done_o),   32'(exp_dn[cyc]));
        chk("bg_busy",   32'(bus.bg_busy_o),   32'(!m_idle()));
        if (bus.bg_valid_o) begin
            if (beats == 0) first_d = int'(bus.bg_data_o);
            last_d = int'(bus.bg_data_o);
            last_beat_cyc = cyc;
            beats++;
        end
        if (bus.bg_done_o) begin
            dones++;
            done_gap = cyc - last_beat_cyc;
        end
        bus.pix_req_i  = preq;
        bus.pix_addr_i = paddr;
        bus.bg_start_i = start;
        bus.bg_base_i  = base;
        bus.bg_len_i   = len;
        bus.bg_abort_i = abort;
        #1;
        running = m_burst && !m_drain;
        chk("rom_addr", 32'(bus.rom_addr_o),
            32'((!preq && running) ? m_next : paddr));
        if (preq) begin
            exp_pv[cyc+LAT+1] = 1'b1;
            exp_pd[cyc+LAT+1] = DW'(paddr);
        end
        if (m_idle()) begin
            if (start) begin
                m_burst = 1'b1;
                m_drain = 1'b0;
                m_next = base;
                m_left = int'(len) + 1;
                m_last_issue = -100;
                m_issues = 0;
            end
        end else if (running) begin
            if (!preq) begin
                exp_bv[cyc+LAT+1] = 1'b1;
                exp_bd[cyc+LAT+1] = DW'(m_next);
                m_next = m_next + 1'b1;
                m_left--;
                m_last_issue = cyc;
                m_issues++;
            end
            if (m_left == 0 || abort) begin
                m_drain = 1'b1;
                m_done_cyc = imax(cyc + 1, m_last_issue + LAT + 1) + 1;
                exp_dn[m_done_cyc] = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        bit            pix_alt;
        int            abort_after;
        int            exp_beats;
        int            exp_first;
        int            exp_last;
    } vec_t;

    vec_t vecs [4];

    task automatic run_vec(input vec_t v);
        bit aborted, restarted, preq, abort, st;
        aborted = 0;
        restarted = 0;
        beats = 0;
        dones = 0;
        done_gap = -1;
        step(1'b0, '0, 1'b1, v.base, v.len, 1'b0);
        for (int k = 0; k < 60; k++) begin
            preq = v.pix_alt ? (k % 2 == 0) : 1'b0;
            abort = 1'b0;
            st = 1'b0;
            if (v.abort_after >= 0 && !aborted && m_issues == v.abort_after) begin
                abort = 1'b1;
                preq = 1'b1;
                aborted = 1'b1;
            end else if (aborted && !restarted) begin
                st = 1'b1;
                restarted = 1'b1;
            end
            step(preq, AW'(k + 'h40), st, 15'h0555, 8'd5, abort);
        end
        chk("beat_count", 32'(beats), 32'(v.exp_beats));
        chk("first_beat", 32'(first_d), 32'(v.exp_first));
        chk("last_beat",  32'(last_d),  32'(v.exp_last));
        chk("done_count", 32'(dones), 32'd1);
        chk("done_gap",   32'(done_gap), 32'd1);
    endtask

    initial begin
        vecs[0] = '{15'h0010, 8'd3, 1'b0, -1, 4, 'h0010, 'h0013};
        vecs[1] = '{15'h7FFE, 8'd3, 1'b0, -1, 4, 'h7FFE, 'h0001};
        vecs[2] = '{15'h0100, 8'd6, 1'b1, -1, 7, 'h0100, 'h0106};
        vecs[3] = '{15'h0200, 8'd9, 1'b0,  2, 2, 'h0200, 'h0201};

        bus.pix_req_i  = 1'b0;
        bus.pix_addr_i = '0;
        bus.bg_start_i = 1'b0;
        bus.bg_base_i  = '0;
        bus.bg_len_i   = '0;
        bus.bg_abort_i = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pix_valid", 32'(bus.pix_valid_o), 32'd0);
        chk("rst_pix_data",  32'(bus.pix_data_o),  32'd0);
        chk("rst_bg_valid",  32'(bus.bg_valid_o),  32'd0);
        chk("rst_bg_data",   32'(bus.bg_data_o),   32'd0);
        chk("rst_bg_done",   32'(bus.bg_done_o),   32'd0);
        chk("rst_bg_busy",   32'(bus.bg_busy_o),   32'd0);
        arst_n = 1'b1;
        @(posedge clk);

        // Pixel sweep 0..127 with no background traffic.
        for (int i = 0; i < 128; i++) step(1'b1, AW'(i), 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset with two burst reads in flight.
        step(1'b0, '0, 1'b1, 15'h0300, 8'd9, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);
        #2 arst_n = 1'b0;
        #1;
        chk("mid_rst_pix_valid", 32'(bus.pix_valid_o), 32'd0);
        chk("mid_rst_bg_valid",  32'(bus.bg_valid_o),  32'd0);
        chk("mid_rst_bg_data",   32'(bus.bg_data_o),   32'd0);
        chk("mid_rst_bg_done",   32'(bus.bg_done_o),   32'd0);
        chk("mid_rst_bg_busy",   32'(bus.bg_busy_o),   32'd0);
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #5 arst_n = 1'b1;
        m_burst = 1'b0;
        m_drain = 1'b0;
        for (int i = cyc; i < NCYC; i++) begin
            exp_pv[i] = 1'b0;
            exp_pd[i] = '0;
            exp_bv[i] = 1'b0;
            exp_bd[i] = '0;
            exp_dn[i] = 1'b0;
        end
        beats = 0;
        dones = 0;
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
        chk("post_rst_beats", 32'(beats), 32'd0);
        chk("post_rst_dones", 32'(dones), 32'd0);

        // Random mixed traffic.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom),
                 $urandom_range(0, 19) == 0, AW'($urandom),
                 LW'($urandom_range(0, 15)), $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
